// File: rtl/riscv_lsu_axi4lite_master.sv
// MEM-stage load/store to single AXI4-Lite transaction bridge; zero-wait latency 3 cycles (misaligned 1).
// Pipeline stalls until mem_done; AXI valids hold with stable payload until their own handshake.
module riscv_lsu_axi4lite_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  axi_clk,
   input  logic                  axi_arstn,
   input  logic                  mem_req,
   input  logic                  mem_we,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [1:0]            mem_size,
   input  logic                  mem_unsigned,
   output logic                  mem_stall,
   output logic                  mem_done,
   output logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  mem_err,
   output logic [ADDR_WIDTH-1:0] maxi_awaddr,
   output logic [2:0]            maxi_awprot,
   output logic                  maxi_awvalid,
   input  logic                  maxi_awready,
   output logic [DATA_WIDTH-1:0] maxi_wdata,
   output logic [STRB_WIDTH-1:0] maxi_wstrb,
   output logic                  maxi_wvalid,
   input  logic                  maxi_wready,
   input  logic [1:0]            maxi_bresp,
   input  logic                  maxi_bvalid,
   output logic                  maxi_bready,
   output logic [ADDR_WIDTH-1:0] maxi_araddr,
   output logic [2:0]            maxi_arprot,
   output logic                  maxi_arvalid,
   input  logic                  maxi_arready,
   input  logic [DATA_WIDTH-1:0] maxi_rdata,
   input  logic [1:0]            maxi_rresp,
   input  logic                  maxi_rvalid,
   output logic                  maxi_rready
);

   typedef enum logic [2:0] {IDLE, WR, WRESP, RADDR, RDATA, DONE} state_t;

   state_t                state_q, state_d;
   logic [1:0]            addr_lo_q, addr_lo_d;
   logic [1:0]            size_q, size_d;
   logic                  uns_q, uns_d;
   logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
   logic                  arvalid_q, arvalid_d, rready_q, rready_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
   logic                  done_q, done_d, err_q, err_d;

   logic                  misaligned;
   logic [DATA_WIDTH-1:0] wdata_rep, rdata_sh, ld_ext;
   logic [STRB_WIDTH-1:0] strb;

   assign misaligned = (mem_size == 2'b11) ||
                       (mem_size == 2'b01 && mem_addr[0]) ||
                       (mem_size == 2'b10 && mem_addr[1:0] != 2'b00);

   always_comb begin
      wdata_rep = mem_wdata;
      strb      = 4'b1111;
      case (mem_size)
         2'b00: begin
            wdata_rep = {4{mem_wdata[7:0]}};
            strb      = 4'b0001 << mem_addr[1:0];
         end
         2'b01: begin
            wdata_rep = {2{mem_wdata[15:0]}};
            strb      = 4'b0011 << mem_addr[1:0];
         end
         default: ;
      endcase
   end

   // Byte lane addressed by the low address bits is moved to bit 0 before extension
   assign rdata_sh = maxi_rdata >> {addr_lo_q, 3'b000};

   always_comb begin
      case (size_q)
         2'b00:   ld_ext = {{24{~uns_q & rdata_sh[7]}}, rdata_sh[7:0]};
         2'b01:   ld_ext = {{16{~uns_q & rdata_sh[15]}}, rdata_sh[15:0]};
         default: ld_ext = maxi_rdata;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      addr_lo_d = addr_lo_q;
      size_d    = size_q;
      uns_d     = uns_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      awaddr_d  = awaddr_q;
      araddr_d  = araddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_req) begin
               addr_lo_d = mem_addr[1:0];
               size_d    = mem_size;
               uns_d     = mem_unsigned;
               rdata_d   = '0;
               err_d     = 1'b0;
               if (misaligned) begin
                  err_d   = 1'b1;
                  done_d  = 1'b1;
                  state_d = DONE;
               end else if (mem_we) begin
                  awaddr_d  = {mem_addr[ADDR_WIDTH-1:2], 2'b00};
                  wdata_d   = wdata_rep;
                  wstrb_d   = strb;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = WR;
               end else begin
                  araddr_d  = {mem_addr[ADDR_WIDTH-1:2], 2'b00};
                  arvalid_d = 1'b1;
                  state_d   = RADDR;
               end
            end
         end
         WR: begin
            // AW and W retire independently; B is only accepted once both have gone
            if (maxi_awready) awvalid_d = 1'b0;
            if (maxi_wready)  wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = WRESP;
            end
         end
         WRESP: begin
            if (maxi_bvalid) begin
               bready_d = 1'b0;
               err_d    = |maxi_bresp;
               done_d   = 1'b1;
               state_d  = DONE;
            end
         end
         RADDR: begin
            if (maxi_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RDATA;
            end
         end
         RDATA: begin
            if (maxi_rvalid) begin
               rready_d = 1'b0;
               err_d    = |maxi_rresp;
               rdata_d  = (|maxi_rresp) ? '0 : ld_ext;
               done_d   = 1'b1;
               state_d  = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge axi_clk or negedge axi_arstn) begin
      if (!axi_arstn) begin
         state_q   <= IDLE;
         addr_lo_q <= '0;
         size_q    <= '0;
         uns_q     <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         awaddr_q  <= '0;
         araddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_lo_q <= addr_lo_d;
         size_q    <= size_d;
         uns_q     <= uns_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         awaddr_q  <= awaddr_d;
         araddr_q  <= araddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         done_q    <= done_d;
      end
   end

   assign mem_stall    = mem_req & ~done_q;
   assign mem_done     = done_q;
   assign mem_rdata    = rdata_q;
   assign mem_err      = err_q;
   assign maxi_awaddr  = awaddr_q;
   assign maxi_awprot  = 3'b000;
   assign maxi_awvalid = awvalid_q;
   assign maxi_wdata   = wdata_q;
   assign maxi_wstrb   = wstrb_q;
   assign maxi_wvalid  = wvalid_q;
   assign maxi_bready  = bready_q;
   assign maxi_araddr  = araddr_q;
   assign maxi_arprot  = 3'b000;
   assign maxi_arvalid = arvalid_q;
   assign maxi_rready  = rready_q;

endmodule
